acc_ctrl: RTL and testbench
===========================

Name: acc_ctrl

Overview:
- Sequencer directly upstream of module_acc.
- Takes the per-pixel partial-sum stream from the convolution PEs, one input channel after another.
- Drives module_acc's RAM read/write ports, the zero flags and curr_data, aligned to the RAM's 1-cycle read latency and cal_acc's 1-cycle latency.
- Flags the final-channel writes so the downstream stage can capture finished OFM pixels from acc_result.

Parameters:
- PIX_NUM, 114*114, pixels per output feature map; equals module_acc DEPTH; must be ≥ 3.
- ADDR_BIT, 14, address width; 2^ADDR_BIT ≥ PIX_NUM.
- CH_BIT, 8, width of the input-channel count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a layer; sampled only in IDLE.
- num_ch  in  CH_BIT  input channels to accumulate; latched on start.
- busy  out  1  high from the start acceptance until the done pulse, inclusive.
- done  out  1  one-cycle pulse after the last RAM write.
- pix_valid  in  1  partial-sum pixel present.
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready.
- pix_data  in  15  partial sum.
- pix_zero  in  1  pix_data is zero.
- read_en  out  1  to module_acc read_en.
- read_addr  out  ADDR_BIT  to module_acc read_addr.
- write_en  out  1  to module_acc write_en.
- write_addr  out  ADDR_BIT  to module_acc write_addr.
- curr_data  out  15  to module_acc curr_data.
- prev_data_zero  out  1  to module_acc; forces the stored value to be treated as 0.
- curr_data_zero  out  1  to module_acc.
- final_valid  out  1  write of the last channel; acc_result is the final OFM value this cycle.

Behaviour:
- Reset (async):
  - State IDLE; all counters and pipeline valids cleared.
  - All outputs 0: busy, done, pix_ready, read_en, write_en, final_valid, addresses, curr_data, both zero flags.
  - Reset mid-layer discards the in-flight pipeline with no further writes. The RAM contents are don't-care; the next layer's channel 0 overrides them through prev_data_zero.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: pix_ready=0. On start with num_ch≠0: latch num_ch, clear pix_cnt and ch_cnt, go to RUN. On start with num_ch=0: go to DONE, with no RAM access.
  - RUN: pix_ready=1. On each accepted pixel (call this cycle T), pix_cnt increments. At PIX_NUM-1, pix_cnt wraps to 0 and ch_cnt increments. When the accepted pixel is pix_cnt=PIX_NUM-1 and ch_cnt=num_ch-1, go to DRAIN.
  - DRAIN: pix_ready=0. Remain until both pipeline stages are empty (exactly 2 cycles), then go to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy=1 in RUN, DRAIN and DONE.
  - start outside IDLE is ignored.
- Cycle T (accept):
  - read_en = pix_valid & pix_ready (combinational).
  - read_addr = pix_cnt (registered counter).
- Stage 1 registers (T+1), aligned with module_acc prev_data:
  - curr_data = pix_data.
  - curr_data_zero = pix_zero.
  - prev_data_zero = (ch_cnt==0).
  - When the stage is empty, all three are 0.
- Stage 2 registers (T+2), aligned with module_acc post_data:
  - write_en = 1.
  - write_addr = read_addr of cycle T.
  - final_valid = 1 if the pixel belonged to channel num_ch-1.
- Throughput and stalls:
  - One pixel per cycle. Gaps in pix_valid insert bubbles; no back-pressure beyond pix_ready.
- Hazards:
  - Within a channel, addresses are unique.
  - At a channel wrap, address 0 is read no earlier than PIX_NUM cycles after its previous read, i.e. after the write at read+2. PIX_NUM ≥ 3 guarantees no read-before-write hazard.
- Data width: pure passthrough; no arithmetic on pix_data. ch_cnt compares use CH_BIT bits.
- Simultaneous events: the last accept and a DRAIN entry share a cycle. The pipeline keeps shifting in DRAIN and DONE is not entered early.

Decomposition:
- Shared package holds:
  - PSUM_W=15;
  - state encoding localparams IDLE/RUN/DRAIN/DONE;
  - default PIX_NUM and ADDR_BIT, so module_acc and acc_ctrl share them.
- One natural sub-module: acc_ctrl_pipe, the 2-stage valid/addr/data/flag delay line. The FSM and counters stay in acc_ctrl.

Test Plan (bench uses PIX_NUM=4, ADDR_BIT=2; bench instantiates module_acc):
- Reset, then start with num_ch=1 and 4 back-to-back pixels 1,2,3,4 -> write_en at cycles T+2..T+5 with addrs 0..3. prev_data_zero=1 throughout. final_valid=1 on all 4 writes. acc_result=1,2,3,4. done pulses 1 cycle after the last write.
- num_ch=3, every pixel = 5 -> final-channel acc_result=15 at each addr. final_valid only on channel 2. prev_data_zero=1 only on channel 0.
- Same as the previous case with pix_valid toggling 1-0-1-0 -> identical results. write_en pattern mirrors the bubbles with 2-cycle lag.
- start with num_ch=0 -> busy high 1 cycle, then done. read_en and write_en never asserted.
- Assert rst while the second channel is in flight -> all outputs 0 immediately and no write_en. Rerun with num_ch=1 -> clean results 1..4.
- start pulsed during RUN -> ignored. Counters and results unchanged. pix_zero=1 with pix_data=0 on pixel 2 -> curr_data_zero=1 aligned with that pixel's stage-1 cycle.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// Shared constants and state encoding for the module_acc sequencer.
package acc_ctrl_pkg;

  localparam int unsigned PSUM_W       = 15;
  localparam int unsigned DEF_PIX_NUM  = 114 * 114;
  localparam int unsigned DEF_ADDR_BIT = 14;
  localparam int unsigned DEF_CH_BIT   = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StRun   = RUN,
    StDrain = DRAIN,
    StDone  = DONE
  } state_e;

endpackage

// File: rtl/acc_ctrl_if.sv
// Partial-sum pixel stream plus the module_acc RAM/flag port bundle.
interface acc_ctrl_if
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
);
  logic                pix_valid;
  logic                pix_ready;
  logic [PSUM_W-1:0]   pix_data;
  logic                pix_zero;
  logic                read_en;
  logic [ADDR_BIT-1:0] read_addr;
  logic                write_en;
  logic [ADDR_BIT-1:0] write_addr;
  logic [PSUM_W-1:0]   curr_data;
  logic                prev_data_zero;
  logic                curr_data_zero;
  logic                final_valid;

  modport master (
    output pix_valid, pix_data, pix_zero,
    input  pix_ready, read_en, read_addr, write_en, write_addr, curr_data,
    input  prev_data_zero, curr_data_zero, final_valid
  );

  modport slave (
    input  pix_valid, pix_data, pix_zero,
    output pix_ready, read_en, read_addr, write_en, write_addr, curr_data,
    output prev_data_zero, curr_data_zero, final_valid
  );
endinterface

// File: rtl/acc_ctrl_pipe.sv
// Two-stage delay line aligning data/flags with the RAM read and the adder output.
module acc_ctrl_pipe
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [ADDR_BIT-1:0] in_addr,
  input  logic [PSUM_W-1:0]   in_data,
  input  logic                in_zero,
  input  logic                in_first,
  input  logic                in_last,
  output logic                s1_valid,
  output logic [PSUM_W-1:0]   curr_data,
  output logic                curr_data_zero,
  output logic                prev_data_zero,
  output logic                write_en,
  output logic [ADDR_BIT-1:0] write_addr,
  output logic                final_valid
);

  logic [ADDR_BIT-1:0] s1_addr;
  logic                s1_last;

  // Empty stages hold all-zero payload so downstream never sees stale flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s1_last        <= 1'b0;
      curr_data      <= '0;
      curr_data_zero <= 1'b0;
      prev_data_zero <= 1'b0;
      write_en       <= 1'b0;
      write_addr     <= '0;
      final_valid    <= 1'b0;
    end else begin
      s1_valid       <= in_valid;
      s1_addr        <= in_valid ? in_addr : '0;
      s1_last        <= in_valid & in_last;
      curr_data      <= in_valid ? in_data : '0;
      curr_data_zero <= in_valid & in_zero;
      prev_data_zero <= in_valid & in_first;
      write_en       <= s1_valid;
      write_addr     <= s1_valid ? s1_addr : '0;
      final_valid    <= s1_valid & s1_last;
    end
  end

endmodule

// File: rtl/acc_ctrl.sv
// Layer sequencer feeding module_acc: FSM, pixel/channel counters and the alignment pipe.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int unsigned PIX_NUM  = DEF_PIX_NUM,
  parameter int unsigned ADDR_BIT = DEF_ADDR_BIT,
  parameter int unsigned CH_BIT   = DEF_CH_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_BIT-1:0] num_ch,
  output logic              busy,
  output logic              done,
  acc_ctrl_if.slave         bus
);

  localparam logic [ADDR_BIT-1:0] LAST_PIX = ADDR_BIT'(PIX_NUM - 1);

  state_e              state_q;
  logic [ADDR_BIT-1:0] pix_cnt_q;
  logic [CH_BIT-1:0]   ch_cnt_q;
  logic [CH_BIT-1:0]   num_ch_q;
  logic                busy_q;
  logic                done_q;
  logic                pix_ready_q;
  logic                s1_valid;
  logic                accept;
  logic                last_pix;
  logic                first_ch;
  logic                last_ch;

  assign accept   = bus.pix_valid & pix_ready_q;
  assign last_pix = (pix_cnt_q == LAST_PIX);
  assign first_ch = (ch_cnt_q == '0);
  assign last_ch  = (ch_cnt_q == num_ch_q - CH_BIT'(1));

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.pix_ready = pix_ready_q;
  assign bus.read_en   = accept;
  assign bus.read_addr = pix_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      ch_cnt_q    <= '0;
      num_ch_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            if (num_ch != '0) begin
              num_ch_q    <= num_ch;
              pix_cnt_q   <= '0;
              ch_cnt_q    <= '0;
              pix_ready_q <= 1'b1;
              state_q     <= StRun;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (last_pix) begin
              pix_cnt_q <= '0;
              ch_cnt_q  <= ch_cnt_q + CH_BIT'(1);
              if (last_ch) begin
                pix_ready_q <= 1'b0;
                state_q     <= StDrain;
              end
            end else begin
              pix_cnt_q <= pix_cnt_q + ADDR_BIT'(1);
            end
          end
        end
        // Stage 2 empties on the same edge stage 1 is seen empty.
        StDrain: begin
          if (!s1_valid) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  acc_ctrl_pipe #(
    .ADDR_BIT(ADDR_BIT)
  ) u_pipe (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (accept),
    .in_addr       (pix_cnt_q),
    .in_data       (bus.pix_data),
    .in_zero       (bus.pix_zero),
    .in_first      (first_ch),
    .in_last       (last_ch),
    .s1_valid      (s1_valid),
    .curr_data     (bus.curr_data),
    .curr_data_zero(bus.curr_data_zero),
    .prev_data_zero(bus.prev_data_zero),
    .write_en      (bus.write_en),
    .write_addr    (bus.write_addr),
    .final_valid   (bus.final_valid)
  );

endmodule

// File: tb/tb_acc_ctrl.sv
// Self-checking bench for acc_ctrl with a behavioural module_acc RAM/adder model.
module tb_acc_ctrl;
  import acc_ctrl_pkg::*;

  localparam int PIX = 4;
  localparam int AB  = 2;
  localparam int CB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CB-1:0] num_ch = '0;
  logic          busy;
  logic          done;

  acc_ctrl_if #(.ADDR_BIT(AB)) bus ();

  acc_ctrl #(
    .PIX_NUM (PIX),
    .ADDR_BIT(AB),
    .CH_BIT  (CB)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .num_ch(num_ch),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [PSUM_W-1:0] stim_data[64];
  logic              stim_zero[64];

  // Logs gathered by the monitor, cleared before each layer.
  int cyc = 0;
  int busy_cnt = 0;
  int acc_cyc[$];
  int wr_cyc[$];
  int wr_addr[$];
  int wr_fin[$];
  int wr_acc[$];
  int done_cyc[$];
  logic [PSUM_W-1:0] s1_cd[1024];
  logic              s1_cdz[1024];
  logic              s1_pdz[1024];

  // Behavioural module_acc: 1-cycle RAM read, 1-cycle adder, write of adder output.
  logic [PSUM_W-1:0] m_ram[PIX];
  logic [PSUM_W-1:0] m_prev = '0;
  logic [PSUM_W-1:0] m_acc = '0;

  always @(negedge clk) begin
    logic [PSUM_W-1:0] nxt_prev;
    logic [PSUM_W-1:0] nxt_acc;
    nxt_prev = m_ram[bus.read_addr];
    nxt_acc  = (bus.prev_data_zero ? '0 : m_prev) + (bus.curr_data_zero ? '0 : bus.curr_data);
    if (bus.read_en) acc_cyc.push_back(cyc);
    if (bus.write_en) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(bus.write_addr));
      wr_fin.push_back(int'(bus.final_valid));
      wr_acc.push_back(int'(m_acc));
      m_ram[bus.write_addr] = m_acc;
    end
    if (cyc < 1024) begin
      s1_cd[cyc]  = bus.curr_data;
      s1_cdz[cyc] = bus.curr_data_zero;
      s1_pdz[cyc] = bus.prev_data_zero;
    end
    if (done) done_cyc.push_back(cyc);
    if (busy) busy_cnt++;
    m_prev = nxt_prev;
    m_acc  = nxt_acc;
    cyc++;
  end

  task automatic clear_logs();
    acc_cyc.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_fin.delete();
    wr_acc.delete();
    done_cyc.delete();
    cyc = 0;
    busy_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 alternating, 2 random. Stops early at stop_at accepts.
  task automatic run_layer(input int nch, input int gap_mode, input int stop_at,
                           input int poke_idx);
    int idx;
    int guard;
    bit v;
    bit acc;
    bit poked;
    idx = 0;
    guard = 0;
    poked = 0;
    v = 0;
    clear_logs();
    start = 1'b1;
    num_ch = CB'(nch);
    tick();
    start = 1'b0;
    while (idx < nch * PIX && idx < stop_at && guard < 500) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ~v;
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.pix_valid = v;
      bus.pix_data  = stim_data[idx];
      bus.pix_zero  = stim_zero[idx];
      if (idx == poke_idx && !poked) begin
        start = 1'b1;
        num_ch = CB'(7);
        poked = 1;
      end
      acc = v && bus.pix_ready;
      tick();
      start = 1'b0;
      if (acc) idx++;
      guard++;
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (done_cyc.size() == 0 && g < 20) begin
      tick();
      g++;
    end
    repeat (2) tick();
  endtask

  task automatic check_layer(input int nch, input string tag);
    logic [PSUM_W-1:0] exp_sum[PIX];
    int n;
    int m;
    n = nch * PIX;
    for (int p = 0; p < PIX; p++) begin
      exp_sum[p] = '0;
      for (int c = 0; c < nch; c++)
        exp_sum[p] += stim_zero[c*PIX+p] ? '0 : stim_data[c*PIX+p];
    end
    n_cmp++;
    if (acc_cyc.size() !== n) begin
      n_err++;
      $display("FAIL %s accept_count: got %0d want %0d", tag, acc_cyc.size(), n);
    end
    n_cmp++;
    if (wr_cyc.size() !== n) begin
      n_err++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wr_cyc.size(), n);
    end
    m = (acc_cyc.size() < wr_cyc.size()) ? acc_cyc.size() : wr_cyc.size();
    for (int i = 0; i < m; i++) begin
      int t;
      t = acc_cyc[i];
      n_cmp++;
      if (wr_cyc[i] !== t + 2) begin
        n_err++;
        $display("FAIL %s wr_lag[%0d]: got cyc %0d want %0d", tag, i, wr_cyc[i], t + 2);
      end
      n_cmp++;
      if (wr_addr[i] !== i % PIX) begin
        n_err++;
        $display("FAIL %s wr_addr[%0d]: got %0d want %0d", tag, i, wr_addr[i], i % PIX);
      end
      n_cmp++;
      if (wr_fin[i] !== int'(i / PIX == nch - 1)) begin
        n_err++;
        $display("FAIL %s final_valid[%0d]: got %0d want %0d", tag, i, wr_fin[i],
                 int'(i / PIX == nch - 1));
      end
      n_cmp++;
      if (s1_pdz[t+1] !== (i / PIX == 0)) begin
        n_err++;
        $display("FAIL %s prev_zero[%0d]: got %0b want %0b", tag, i, s1_pdz[t+1], i / PIX == 0);
      end
      n_cmp++;
      if (s1_cdz[t+1] !== stim_zero[i] || s1_cd[t+1] !== stim_data[i]) begin
        n_err++;
        $display("FAIL %s curr[%0d]: got %0d/%0b want %0d/%0b", tag, i, s1_cd[t+1],
                 s1_cdz[t+1], stim_data[i], stim_zero[i]);
      end
      if (i / PIX == nch - 1) begin
        n_cmp++;
        if (wr_acc[i] !== int'(exp_sum[i % PIX])) begin
          n_err++;
          $display("FAIL %s acc_result[%0d]: got %0d want %0d", tag, i, wr_acc[i],
                   exp_sum[i % PIX]);
        end
      end
    end
    n_cmp++;
    if (done_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL %s done_count: got %0d want 1", tag, done_cyc.size());
    end else begin
      n_cmp++;
      if (wr_cyc.size() > 0 && done_cyc[0] !== wr_cyc[wr_cyc.size()-1] + 1) begin
        n_err++;
        $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc[0],
                 wr_cyc[wr_cyc.size()-1] + 1);
      end
      n_cmp++;
      if (busy_cnt !== done_cyc[0]) begin
        n_err++;
        $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, done_cyc[0]);
      end
    end
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 64; i++) begin
      stim_data[i] = PSUM_W'(i + 1);
      stim_zero[i] = 1'b0;
    end
  endtask

  task automatic fill_const(input int val);
    for (int i = 0; i < 64; i++) begin
      stim_data[i] = PSUM_W'(val);
      stim_zero[i] = 1'b0;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      stim_zero[i] = ($urandom_range(0, 3) == 0);
      stim_data[i] = stim_zero[i] ? '0 : PSUM_W'($urandom_range(1, 2000));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    bus.pix_data = '1;
    bus.pix_zero = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bus.pix_ready, bus.read_en, bus.write_en, bus.final_valid, bus.read_addr,
         bus.write_addr, bus.curr_data, bus.prev_data_zero, bus.curr_data_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: busy=%b done=%b rdy=%b ren=%b wen=%b fin=%b cd=%h", busy,
               done, bus.pix_ready, bus.read_en, bus.write_en, bus.final_valid, bus.curr_data);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.read_en !== 1'b0 || bus.pix_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_not_ready: got rdy=%b ren=%b want 0 0", bus.pix_ready, bus.read_en);
    end
    bus.pix_valid = 1'b0;
    bus.pix_zero = 1'b0;
  endtask

  task automatic test_single();
    fill_seq();
    run_layer(1, 0, 1000, -1);
    wait_done();
    check_layer(1, "single");
  endtask

  task automatic test_three_ch();
    fill_const(5);
    run_layer(3, 0, 1000, -1);
    wait_done();
    check_layer(3, "three_ch");
  endtask

  task automatic test_bubbles();
    fill_const(5);
    run_layer(3, 1, 1000, -1);
    wait_done();
    check_layer(3, "bubbles");
  endtask

  task automatic test_zero_ch();
    run_layer(0, 0, 1000, -1);
    wait_done();
    n_cmp++;
    if (busy_cnt !== 1 || done_cyc.size() !== 1) begin
      n_err++;
      $display("FAIL zero_ch_busy_done: got busy %0d done %0d want 1 1", busy_cnt,
               done_cyc.size());
    end
    n_cmp++;
    if (done_cyc.size() > 0 && done_cyc[0] !== 1) begin
      n_err++;
      $display("FAIL zero_ch_done_cycle: got %0d want 1", done_cyc[0]);
    end
    n_cmp++;
    if (acc_cyc.size() !== 0 || wr_cyc.size() !== 0) begin
      n_err++;
      $display("FAIL zero_ch_ram_access: got reads %0d writes %0d want 0 0", acc_cyc.size(),
               wr_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int nwr;
    fill_rand();
    run_layer(3, 0, PIX + 2, -1);
    nwr = wr_cyc.size();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bus.pix_ready, bus.read_en, bus.write_en, bus.final_valid, bus.read_addr,
         bus.write_addr, bus.curr_data, bus.prev_data_zero, bus.curr_data_zero} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: busy=%b rdy=%b wen=%b cd=%h pdz=%b want all 0", busy,
               bus.pix_ready, bus.write_en, bus.curr_data, bus.prev_data_zero);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (wr_cyc.size() !== nwr) begin
      n_err++;
      $display("FAIL mid_reset_no_write: got %0d writes want %0d", wr_cyc.size(), nwr);
    end
    fill_seq();
    run_layer(1, 0, 1000, -1);
    wait_done();
    check_layer(1, "after_reset");
  endtask

  task automatic test_start_in_run();
    fill_rand();
    stim_data[2] = '0;
    stim_zero[2] = 1'b1;
    run_layer(2, 0, 1000, 1);
    wait_done();
    check_layer(2, "start_in_run");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run_layer(int'($urandom_range(1, 5)), 2, 1000, -1);
      wait_done();
      check_layer(int'(num_ch), "random");
    end
  endtask

  initial begin
    for (int i = 0; i < PIX; i++) m_ram[i] = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.pix_zero = 1'b0;
    test_reset();
    test_single();
    test_three_ch();
    test_bubbles();
    test_zero_ch();
    test_reset_mid();
    test_start_in_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
